// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit.
// Accepts a load or store from EX/MEM and runs one request/acknowledge
// transaction on the data-memory bus. It drives byte-lane enables and
// lane-replicated store data. It extracts and extends sub-word load data
// into a registered result for MEM/WB. It stalls the upstream pipeline
// until the access completes.
// Optional feature macro: MEM_ALIGN_CHECK_EN. When it is defined,
// misaligned half/word accesses skip the bus and raise misalign for one cycle.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memrd,
  input  logic              memwr,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rddata,
  output logic              stall,
  output logic              misalign,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // Byte enables for a given size and low address bits (little-endian lanes).
  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated so that every enabled lane sees the right bytes.
  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    case (sz)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Select the addressed lane(s) of the read word and extend to 32 bits.
  function automatic logic [31:0] load_extract(input logic [1:0]  sz,
                                               input logic [1:0]  lo,
                                               input logic        sx,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'b00:   b = d[7:0];
      2'b01:   b = d[15:8];
      2'b10:   b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lo[1] ? d[31:16] : d[15:0];
    case (sz)
      2'b00:   r = {{24{sx & b[7]}}, b};
      2'b01:   r = {{16{sx & h[15]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  // Half needs addr[0]==0, word needs addr[1:0]==0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    logic m;
    case (sz)
      2'b00:   m = 1'b0;
      2'b01:   m = lo[0];
      default: m = (lo != 2'b00);
    endcase
    return m;
  endfunction
`endif

  state_t            state_r;
  logic              bus_req_r;
  logic              bus_we_r;
  logic [ADDR_W-1:0] bus_addr_r;
  logic [3:0]        bus_be_r;
  logic [31:0]       bus_wdata_r;
  logic [31:0]       rddata_r;
  logic [1:0]        size_r;
  logic [1:0]        addr_lo_r;
  logic              sext_r;
`ifdef MEM_ALIGN_CHECK_EN
  logic              misalign_r;
`endif

  logic              access_s;
  logic              ack_s;
  logic              mis_s;
  logic              stall_s;

  assign access_s = memrd | memwr;
  // An ack only counts while a request is actually on the bus.
  assign ack_s    = bus_ack & bus_req_r;

`ifdef MEM_ALIGN_CHECK_EN
  assign mis_s    = is_misaligned(size, addr[1:0]);
  assign misalign = misalign_r;
`else
  assign mis_s    = 1'b0;
  assign misalign = 1'b0;
`endif

  // Pipeline freeze: the detect cycle in IDLE plus every BUSY cycle, never in reset.
  always_comb begin
    stall_s = 1'b0;
    if (rst) begin
      stall_s = 1'b0;
    end else if (state_r == BUSY) begin
      stall_s = 1'b1;
    end else if ((state_r == IDLE) && access_s) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  assign stall     = stall_s;
  assign rddata    = rddata_r;
  assign bus_req   = bus_req_r;
  assign bus_we    = bus_we_r;
  assign bus_addr  = bus_addr_r;
  assign bus_be    = bus_be_r;
  assign bus_wdata = bus_wdata_r;

  // Access FSM: captures the MEM-stage request, drives the bus and registers load data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= {ADDR_W{1'b0}};
      bus_be_r    <= 4'b0000;
      bus_wdata_r <= 32'h0000_0000;
      rddata_r    <= 32'h0000_0000;
      size_r      <= 2'b00;
      addr_lo_r   <= 2'b00;
      sext_r      <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (access_s) begin
            size_r    <= size;
            addr_lo_r <= addr[1:0];
            sext_r    <= sext;
            if (mis_s) begin
              // Misaligned: no bus cycle, flag it and return a zero result.
              state_r  <= DONE;
              rddata_r <= 32'h0000_0000;
`ifdef MEM_ALIGN_CHECK_EN
              misalign_r <= 1'b1;
`endif
            end else begin
              state_r     <= BUSY;
              bus_req_r   <= 1'b1;
              // A simultaneous load and store is handled as a load only.
              bus_we_r    <= memwr & ~memrd;
              bus_addr_r  <= {addr[ADDR_W-1:2], 2'b00};
              bus_be_r    <= lane_be(size, addr[1:0]);
              bus_wdata_r <= lane_wdata(size, wdata);
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (ack_s) begin
            state_r   <= DONE;
            bus_req_r <= 1'b0;
            bus_we_r  <= 1'b0;
            bus_be_r  <= 4'b0000;
            if (!bus_we_r) begin
              rddata_r <= load_extract(size_r, addr_lo_r, sext_r, bus_rdata);
            end else begin
              rddata_r <= rddata_r;
            end
          end else begin
            state_r <= BUSY;
          end
        end
        DONE: begin
          // Inputs still show the finished instruction, so they are ignored here.
          state_r <= IDLE;
`ifdef MEM_ALIGN_CHECK_EN
          misalign_r <= 1'b0;
`endif
        end
        default: begin
          state_r   <= IDLE;
          bus_req_r <= 1'b0;
          bus_we_r  <= 1'b0;
          bus_be_r  <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (ADDR_W = 32).
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        memrd;
  logic        memwr;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rddata;
  logic        stall;
  logic        misalign;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .memrd     (memrd),
    .memwr     (memwr),
    .size      (size),
    .sext      (sext),
    .addr      (addr),
    .wdata     (wdata),
    .rddata    (rddata),
    .stall     (stall),
    .misalign  (misalign),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sx, input logic [31:0] a, input logic [31:0] d);
    memrd = rd; memwr = wr; size = sz; sext = sx; addr = a; wdata = d;
  endtask

  task automatic quiet();
    memrd = 1'b0; memwr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; memrd = 1'b1; memwr = 1'b0; size = 2'b10; sext = 1'b0;
    addr = 32'h0; wdata = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
    tick(); tick();
    // Reset state: stall must stay low even with memrd high.
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_rddata", rddata, 32'h0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    rst = 1'b0; quiet();
    tick();

    // Word store 0x104, immediate ack.
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF);
    #1 chk("ws_idle_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("ws_req", {31'd0, bus_req}, 32'd1);
    chk("ws_we", {31'd0, bus_we}, 32'd1);
    chk("ws_addr", bus_addr, 32'h104);
    chk("ws_be", {28'd0, bus_be}, 32'hF);
    chk("ws_wdata", bus_wdata, 32'hDEADBEEF);
    chk("ws_busy_stall", {31'd0, stall}, 32'd1);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("ws_done_req", {31'd0, bus_req}, 32'd0);
    chk("ws_done_stall", {31'd0, stall}, 32'd0);
    quiet();
    tick();
    chk("ws_idle2_stall", {31'd0, stall}, 32'd0);

    // Byte load 0x203 sign-extended.
    issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h203, 32'h0);
    tick();
    chk("bl_be", {28'd0, bus_be}, 32'h8);
    chk("bl_addr", bus_addr, 32'h200);
    chk("bl_we", {31'd0, bus_we}, 32'd0);
    bus_rdata = 32'h80FF1234; bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("bl_sext", rddata, 32'hFFFFFF80);
    quiet();
    tick();

    // Same byte load zero-extended.
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h203, 32'h0);
    tick();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("bl_zext", rddata, 32'h00000080);
    quiet();
    tick();

    // Half load 0x06 sign-extended: upper half 0x8001.
    issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h06, 32'h0);
    tick();
    chk("hl_be", {28'd0, bus_be}, 32'hC);
    bus_rdata = 32'h80017FFF; bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("hl_sext", rddata, 32'hFFFF8001);
    quiet();
    tick();

    // Byte store 0x201: lane 1, data replicated.
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h201, 32'h123456A7);
    tick();
    chk("bs_be", {28'd0, bus_be}, 32'h2);
    chk("bs_wdata", bus_wdata, 32'hA7A7A7A7);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("bs_rddata_hold", rddata, 32'hFFFF8001);
    quiet();
    tick();

    // Half store 0x12, ack after 3 wait cycles: 4 BUSY cycles, stall 5 cycles.
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000ABCD);
    #1 chk("hs_idle_stall", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hs_req", {31'd0, bus_req}, 32'd1);
      chk("hs_be", {28'd0, bus_be}, 32'hC);
      chk("hs_wdata", bus_wdata, 32'hABCDABCD);
      chk("hs_addr", bus_addr, 32'h10);
      chk("hs_stall", {31'd0, stall}, 32'd1);
      if (i == 3) bus_ack = 1'b1;
      else bus_ack = 1'b0;
    end
    tick();
    bus_ack = 1'b0;
    chk("hs_done_req", {31'd0, bus_req}, 32'd0);
    chk("hs_done_stall", {31'd0, stall}, 32'd0);
    quiet();
    tick();

    // Reset in the second BUSY cycle of a word load.
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    tick();
    tick();
    chk("rb_req_busy2", {31'd0, bus_req}, 32'd1);
    rst = 1'b1; quiet();
    #1 chk("rb_stall_in_rst", {31'd0, stall}, 32'd0);
    tick();
    chk("rb_req", {31'd0, bus_req}, 32'd0);
    chk("rb_rddata", rddata, 32'h0);
    chk("rb_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0; bus_rdata = 32'h12345678; bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("rb_stray_ack_req", {31'd0, bus_req}, 32'd0);
    chk("rb_stray_ack_rd", rddata, 32'h0);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
    tick();
    chk("rb_next_req", {31'd0, bus_req}, 32'd1);
    chk("rb_next_addr", bus_addr, 32'h44);
    bus_rdata = 32'hCAFEF00D; bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("rb_next_rd", rddata, 32'hCAFEF00D);
    quiet();
    tick();

    // Word load at 0x102.
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    #1 chk("ma_idle_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("ma_req", {31'd0, bus_req}, 32'd0);
    chk("ma_flag", {31'd0, misalign}, 32'd1);
    chk("ma_rddata", rddata, 32'h0);
    chk("ma_stall", {31'd0, stall}, 32'd0);
    quiet();
    tick();
    chk("ma_flag_clear", {31'd0, misalign}, 32'd0);
`else
    tick();
    chk("ma_req", {31'd0, bus_req}, 32'd1);
    chk("ma_addr", bus_addr, 32'h100);
    chk("ma_be", {28'd0, bus_be}, 32'hF);
    bus_rdata = 32'h11223344; bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("ma_rddata", rddata, 32'h11223344);
    chk("ma_flag", {31'd0, misalign}, 32'd0);
    quiet();
    tick();
`endif

    // memrd and memwr together: performed as a load; then a back-to-back load.
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hFFFFFFFF);
    tick();
    chk("rw_we", {31'd0, bus_we}, 32'd0);
    chk("rw_addr", bus_addr, 32'h40);
    bus_rdata = 32'hA5A5A5A5; bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("rw_rddata", rddata, 32'hA5A5A5A5);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h48, 32'h0);
    tick();
    chk("b2b_idle_stall", {31'd0, stall}, 32'd1);
    chk("b2b_idle_req", {31'd0, bus_req}, 32'd0);
    tick();
    chk("b2b_req", {31'd0, bus_req}, 32'd1);
    chk("b2b_addr", bus_addr, 32'h48);
    bus_rdata = 32'h5A5A0000; bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("b2b_rddata", rddata, 32'h5A5A0000);
    quiet();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
